// File: rtl/capi_cmd_gate_pkg.sv
// Shared types and constants for the CAPI command issue gate.
// Holds the gate's state encoding and the sticky error bit positions.
package capi_cmd_gate_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int ERR_BAD_TAG   = 0;
  localparam int ERR_CRED_OVF  = 1;
  localparam int ERR_INIT_BUSY = 2;
  localparam int ERR_W         = 3;

endpackage

// File: rtl/capi_tag_freelist.sv
// Free list of PSL tags: a 2**tag_width deep FIFO with simultaneous push/pop.
// The head entry is visible on pop_tag whenever the list is not empty.
module capi_tag_freelist #(
  parameter int tag_width = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic [tag_width-1:0] push_tag,
  input  logic                 pop,
  output logic [tag_width-1:0] pop_tag,
  output logic                 empty,
  output logic                 full
);

  localparam int ntags = 2**tag_width;

  logic [tag_width-1:0] mem [ntags];
  logic [tag_width-1:0] rd_ptr;
  logic [tag_width-1:0] wr_ptr;
  logic [tag_width:0]   count;
  logic                 do_push;
  logic                 do_pop;

  assign empty   = (count == '0);
  assign full    = count[tag_width];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign pop_tag = mem[rd_ptr];

  // NOTE: the storage array has no reset; only pointers and count need one,
  // since an entry is never read before it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_tag;
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + tag_width'(1);
      if (do_pop)  rd_ptr <= rd_ptr + tag_width'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (tag_width+1)'(1);
        2'b01:   count <= count - (tag_width+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/capi_cmd_gate.sv
// Command issue gate between the AFU arbiter and the PSL command interface:
// tag allocation from a free list, credit enforcement, and issue/response reporting.
module capi_cmd_gate
  import capi_cmd_gate_pkg::*;
#(
  parameter int tag_width  = 6,
  parameter int cred_width = 8,
  parameter int cmd_width  = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_cmd_en,
  input  logic                  i_cred_init_v,
  input  logic [cred_width-1:0] i_cred_init_d,
  input  logic                  i_req_v,
  output logic                  o_req_r,
  input  logic [cmd_width-1:0]  i_req_d,
  output logic                  o_cmd_v,
  output logic [tag_width-1:0]  o_cmd_tag,
  output logic [cmd_width-1:0]  o_cmd_d,
  input  logic                  i_rsp_v,
  input  logic [tag_width-1:0]  i_rsp_tag,
  output logic                  o_rsp_v,
  output logic [tag_width-1:0]  o_rsp_tag,
  output logic                  o_cmd_sent,
  output logic                  o_rsp_rcvd,
  output logic                  o_init_done,
  output logic [ERR_W-1:0]      o_err
);

  localparam int ntags = 2**tag_width;

  state_t                state, state_nxt;
  logic [tag_width-1:0]  init_cnt;
  logic [cred_width-1:0] cred, cred_nxt, cred_max, outst_cnt;
  logic [ntags-1:0]      outst;
  logic [ERR_W-1:0]      err;

  logic                  run, accept, rsp_in, rsp_ok, rsp_bad;
  logic                  cred_load, init_busy, cred_ovf;
  logic                  fl_push, fl_empty, fl_full;
  logic [tag_width-1:0]  fl_push_tag, fl_pop_tag;

  assign run       = (state == ST_RUN);
  assign accept    = run & i_req_v & i_cmd_en & (cred != '0) & ~fl_empty;
  assign rsp_in    = run & i_rsp_v;
  assign rsp_ok    = rsp_in & outst[i_rsp_tag];
  assign rsp_bad   = rsp_in & ~outst[i_rsp_tag];
  assign cred_load = i_cred_init_v & (outst_cnt == '0);
  assign init_busy = i_cred_init_v & (outst_cnt != '0);

  assign o_req_r     = accept;
  assign o_init_done = run;
  assign o_err       = err;

  capi_tag_freelist #(.tag_width(tag_width)) u_freelist (
    .clk      (clk),
    .reset    (reset),
    .push     (fl_push),
    .push_tag (fl_push_tag),
    .pop      (accept),
    .pop_tag  (fl_pop_tag),
    .empty    (fl_empty),
    .full     (fl_full)
  );

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt   = state;
    fl_push     = 1'b0;
    fl_push_tag = '0;
    unique case (state)
      ST_INIT: begin
        fl_push     = 1'b1;
        fl_push_tag = init_cnt;
        if (init_cnt == '1) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        fl_push     = rsp_ok & ~fl_full;
        fl_push_tag = i_rsp_tag;
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  // A load replaces the count outright; otherwise issue and return cancel when simultaneous.
  always_comb begin
    cred_nxt = cred;
    cred_ovf = 1'b0;
    if (cred_load) begin
      cred_nxt = i_cred_init_d;
    end else if (accept && !rsp_ok) begin
      cred_nxt = cred - cred_width'(1);
    end else if (rsp_ok && !accept) begin
      if (cred >= cred_max) begin
        cred_ovf = 1'b1;
        cred_nxt = cred_max;
      end else begin
        cred_nxt = cred + cred_width'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_INIT;
      init_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_INIT) init_cnt <= init_cnt + tag_width'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cred      <= '0;
      cred_max  <= '0;
      outst_cnt <= '0;
      outst     <= '0;
      err       <= '0;
    end else begin
      cred <= cred_nxt;
      if (cred_load) cred_max <= i_cred_init_d;
      unique case ({accept, rsp_ok})
        2'b10:   outst_cnt <= outst_cnt + cred_width'(1);
        2'b01:   outst_cnt <= outst_cnt - cred_width'(1);
        default: outst_cnt <= outst_cnt;
      endcase
      // The popped tag is free, the returning one outstanding, so they never collide.
      if (accept) outst[fl_pop_tag] <= 1'b1;
      if (rsp_ok) outst[i_rsp_tag]  <= 1'b0;
      if (rsp_bad)   err[ERR_BAD_TAG]   <= 1'b1;
      if (cred_ovf)  err[ERR_CRED_OVF]  <= 1'b1;
      if (init_busy) err[ERR_INIT_BUSY] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_cmd_v    <= 1'b0;
      o_cmd_sent <= 1'b0;
      o_cmd_tag  <= '0;
      o_cmd_d    <= '0;
      o_rsp_v    <= 1'b0;
      o_rsp_rcvd <= 1'b0;
      o_rsp_tag  <= '0;
    end else begin
      o_cmd_v    <= accept;
      o_cmd_sent <= accept;
      o_rsp_v    <= rsp_in;
      o_rsp_rcvd <= rsp_in;
      if (accept) begin
        o_cmd_tag <= fl_pop_tag;
        o_cmd_d   <= i_req_d;
      end
      if (rsp_in) o_rsp_tag <= i_rsp_tag;
    end
  end

endmodule

// File: tb/tb_capi_cmd_gate.sv
// Self-checking bench for capi_cmd_gate: directed scenarios with literal
// expectations plus randomized traffic against a queue-based behavioural model.
module tb_capi_cmd_gate;

  localparam int TW = 6;
  localparam int CW = 8;
  localparam int DW = 64;
  localparam int NT = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_en, cred_init_v, req_v, rsp_v;
  logic [CW-1:0] cred_init_d;
  logic [DW-1:0] req_d;
  logic [TW-1:0] rsp_tag;
  logic          req_r, cmd_v, rsp_vo, cmd_sent, rsp_rcvd, init_done;
  logic [TW-1:0] cmd_tag, rsp_tago;
  logic [DW-1:0] cmd_d;
  logic [2:0]    err;

  int total = 0;
  int bad   = 0;

  capi_cmd_gate #(.tag_width(TW), .cred_width(CW), .cmd_width(DW)) dut (
    .clk           (clk),
    .reset         (reset),
    .i_cmd_en      (cmd_en),
    .i_cred_init_v (cred_init_v),
    .i_cred_init_d (cred_init_d),
    .i_req_v       (req_v),
    .o_req_r       (req_r),
    .i_req_d       (req_d),
    .o_cmd_v       (cmd_v),
    .o_cmd_tag     (cmd_tag),
    .o_cmd_d       (cmd_d),
    .i_rsp_v       (rsp_v),
    .i_rsp_tag     (rsp_tag),
    .o_rsp_v       (rsp_vo),
    .o_rsp_tag     (rsp_tago),
    .o_cmd_sent    (cmd_sent),
    .o_rsp_rcvd    (rsp_rcvd),
    .o_init_done   (init_done),
    .o_err         (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_q[$];
  bit [NT-1:0] m_outst;
  int          m_cred, m_max, m_outcnt, m_initcyc;
  bit          m_done;
  bit [2:0]    m_err;
  bit          e_cmd_v, e_rsp_v;
  int          e_cmd_tag, e_rsp_tag;
  logic [63:0] e_cmd_d;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_q.delete();
      m_outst = '0; m_cred = 0; m_max = 0; m_outcnt = 0; m_initcyc = 0;
      m_done = 0; m_err = '0;
      e_cmd_v = 0; e_rsp_v = 0; e_cmd_tag = 0; e_rsp_tag = 0; e_cmd_d = '0;
    end else begin
      bit ld, acc, good;
      int t;
      ld = cred_init_v && (m_outcnt == 0);
      if (cred_init_v && !ld) m_err[2] = 1;
      e_cmd_v = 0;
      e_rsp_v = 0;
      if (!m_done) begin
        m_q.push_back(m_initcyc);
        m_initcyc++;
        if (m_initcyc == NT) m_done = 1;
      end else begin
        acc  = req_v && cmd_en && (m_cred != 0) && (m_q.size() != 0);
        good = rsp_v && m_outst[rsp_tag];
        if (acc) begin
          t = m_q.pop_front();
          m_outst[t] = 1;
          m_outcnt++;
          e_cmd_v = 1; e_cmd_tag = t; e_cmd_d = req_d;
        end
        if (good) begin
          m_q.push_back(int'(rsp_tag));
          m_outst[rsp_tag] = 0;
          m_outcnt--;
        end
        if (rsp_v && !good) m_err[0] = 1;
        if (rsp_v) begin e_rsp_v = 1; e_rsp_tag = int'(rsp_tag); end
        if (!ld) begin
          if (acc && !good) m_cred--;
          else if (good && !acc) begin
            if (m_cred + 1 > m_max) begin m_err[1] = 1; m_cred = m_max; end
            else m_cred++;
          end
        end
      end
      if (ld) begin m_cred = int'(cred_init_d); m_max = int'(cred_init_d); end
    end
  end

  // Compare on the falling edge, half a cycle away from the active edge.
  always @(negedge clk) begin
    bit pred_req;
    pred_req = m_done && req_v && cmd_en && (m_cred != 0) && (m_q.size() != 0);
    check("req_r", req_r, pred_req);
    check("cmd_v", cmd_v, e_cmd_v);
    check("cmd_sent", cmd_sent, e_cmd_v);
    check("rsp_v", rsp_vo, e_rsp_v);
    check("rsp_rcvd", rsp_rcvd, e_rsp_v);
    check("init_done", init_done, m_done);
    check("err", err, m_err);
    check("cred", dut.cred, m_cred);
    if (e_cmd_v) begin
      check("cmd_tag", cmd_tag, e_cmd_tag);
      check("cmd_d", cmd_d, e_cmd_d);
    end
    if (e_rsp_v) check("rsp_tag", rsp_tago, e_rsp_tag);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_outs"}, {req_r, cmd_v, rsp_vo, cmd_sent, rsp_rcvd, init_done}, 0);
    check({name, "_err"}, err, 0);
    check({name, "_tags"}, {cmd_tag, rsp_tago}, 0);
    check({name, "_cmd_d"}, cmd_d, 0);
    check({name, "_cred"}, dut.cred, 0);
    check({name, "_outst"}, dut.outst, 0);
  endtask

  task automatic pick_outstanding(output bit found, output int tag);
    int list[$];
    for (int i = 0; i < NT; i++) if (m_outst[i]) list.push_back(i);
    found = (list.size() != 0);
    tag = found ? list[$urandom_range(0, list.size() - 1)] : 0;
  endtask

  task automatic run_random(input int cycles, input int rsp_pct);
    bit found;
    int tag;
    for (int c = 0; c < cycles; c++) begin
      req_v  = ($urandom_range(0, 3) != 0);
      cmd_en = ($urandom_range(0, 7) != 0);
      req_d  = {$urandom, $urandom};
      rsp_v  = 0;
      if ($urandom_range(0, 99) < rsp_pct) begin
        pick_outstanding(found, tag);
        rsp_v = found; rsp_tag = TW'(tag);
      end else if ($urandom_range(0, 39) == 0) begin
        rsp_v = 1; rsp_tag = TW'($urandom_range(0, NT - 1));
      end
      cred_init_v = !req_v && ($urandom_range(0, 99) == 0);
      cred_init_d = CW'($urandom_range(1, 40));
      tick();
    end
    req_v = 0; rsp_v = 0; cred_init_v = 0;
  endtask

  task automatic drain();
    bit found;
    int tag;
    req_v = 0;
    for (int c = 0; c < 200; c++) begin
      pick_outstanding(found, tag);
      rsp_v = found; rsp_tag = TW'(tag);
      tick();
    end
    rsp_v = 0;
    tick();
    check("drain_outcnt", dut.outst_cnt, 0);
  endtask

  initial begin
    reset = 0; cmd_en = 0; cred_init_v = 0; cred_init_d = '0;
    req_v = 0; req_d = '0; rsp_v = 0; rsp_tag = '0;
    tick(); tick();
    check_all_zero("reset");
    reset = 1;

    for (int i = 0; i < 63; i++) tick();
    check("init_done_63", init_done, 0);
    tick();
    check("init_done_64", init_done, 1);

    cred_init_v = 1; cred_init_d = 8'd4;
    tick();
    cred_init_v = 0;
    check("cred_load4", dut.cred, 4);

    req_v = 1; cmd_en = 1;
    for (int k = 0; k < 4; k++) begin
      req_d = 64'hA5A5_0000_0000_0000 + 64'(k);
      #1 check("first4_req_r", req_r, 1);
      tick();
      check("first4_sent", cmd_sent, 1);
      check("first4_tag", cmd_tag, k);
    end
    check("fifth_stall", req_r, 0);
    tick();
    check("fifth_no_cmd", cmd_v, 0);

    rsp_v = 1; rsp_tag = 6'd2;
    tick();
    rsp_v = 0;
    check("ret2_rcvd", rsp_rcvd, 1);
    check("ret2_tag", rsp_tago, 2);
    check("ret2_req_r", req_r, 1);
    check("model_tail", m_q[m_q.size() - 1], 2);
    tick();
    req_v = 0;
    check("tag4_sent", cmd_sent, 1);
    check("tag4_tag", cmd_tag, 4);

    rsp_v = 1; rsp_tag = 6'd0;
    tick();
    rsp_v = 0;
    req_v = 1; cmd_en = 0;
    #1 check("en_low_req_r", req_r, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("en_low_no_cmd", cmd_v, 0);
    end
    cmd_en = 1;
    #1 check("en_high_req_r", req_r, 1);
    tick();
    req_v = 0;
    check("en_high_sent", cmd_sent, 1);
    check("en_high_tag", cmd_tag, 5);

    rsp_v = 1; rsp_tag = 6'd9;
    tick();
    rsp_v = 0;
    check("bad9_err", err, 3'b001);
    check("bad9_rcvd", rsp_rcvd, 1);
    check("bad9_cred", dut.cred, 0);

    rsp_v = 1; rsp_tag = 6'd1;
    tick();
    check("ret1_cred", dut.cred, 1);
    req_v = 1; rsp_tag = 6'd3;
    #1 check("simul_req_r", req_r, 1);
    tick();
    req_v = 0; rsp_v = 0;
    check("simul_cred", dut.cred, 1);
    check("simul_sent", cmd_sent, 1);
    check("simul_rcvd", rsp_rcvd, 1);
    check("simul_tag", cmd_tag, 6);

    cred_init_v = 1; cred_init_d = 8'd8;
    tick();
    cred_init_v = 0;
    check("busy_err", err, 3'b101);
    check("busy_cred", dut.cred, 1);

    check("pre_reset_outst", dut.outst_cnt, 3);
    reset = 0;
    #1 check_all_zero("midreset");
    tick(); tick();
    reset = 1;
    for (int i = 0; i < 64; i++) tick();
    check("reinit_done", init_done, 1);
    cred_init_v = 1; cred_init_d = 8'd16;
    tick();
    cred_init_v = 0;
    check("reload_err", err, 0);
    check("reload_cred", dut.cred, 16);

    run_random(1500, 35);
    drain();
    cred_init_v = 1; cred_init_d = 8'd100;
    tick();
    cred_init_v = 0;
    run_random(1500, 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
